// File: rtl/ram_seq.sv
// ram_seq: command sequencer sitting directly upstream of a 32x8 synchronous
// RAM. It accepts single or burst read/write commands over a valid/ready
// handshake. It drives the RAM's registered control strobes, one word per
// cycle, and returns read data as a stream tagged with its source address.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset (aborts any burst)
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (high only in IDLE)
//   cmd_op     00 WRITE, 01 READ, 10 FILL, 11 DUMP
//   cmd_addr   start address
//   cmd_len    burst length minus 1 (FILL/DUMP only)
//   cmd_data   write/fill data
//   cmd_inc    FILL only: data increments by 1 per word
//   ram_cs, ram_read, ram_write, ram_addr, ram_wdata   RAM control pins
//   ram_rdata  RAM read data (one-cycle latency after a read strobe)
//   rd_valid   rd_data/rd_addr valid this cycle
//   rd_data    read word (pass-through of ram_rdata)
//   rd_addr    address the read word came from
//   busy       sequencer is not idle
//   done       one-cycle pulse when a command fully completes
module ram_seq #(
  parameter int DW     = 8,
  parameter int AW     = 5,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [AW-1:0]     cmd_len,
  input  logic [DW-1:0]     cmd_data,
  input  logic              cmd_inc,
  output logic              ram_cs,
  output logic              ram_read,
  output logic              ram_write,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [AW-1:0]     rd_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  localparam logic [1:0] OP_FILL = 2'b10;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                inc_q, inc_d;

  logic                cs_d, read_d, write_d;
  logic [RAM_AW-1:0]   addr_d;
  logic [DW-1:0]       wdata_d;
  logic                rd_valid_d;
  logic [AW-1:0]       rd_addr_d;
  logic                ready_d, done_d;
  logic [AW-1:0]       addr_inc;

  // Address arithmetic stays in AW bits so bursts wrap at DEPTH; the upper
  // RAM address bits are only ever zero-extended.
  assign addr_inc = ram_addr[AW-1:0] + AW'(1);

  assign rd_data = ram_rdata;

  // cnt_q holds the number of strobes still to issue after the one currently
  // on the RAM pins, so cnt_q == 0 marks the last strobe of a burst.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inc_d      = inc_q;
    cs_d       = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    addr_d     = ram_addr;
    wdata_d    = ram_wdata;
    rd_valid_d = ram_cs & ram_read;
    rd_addr_d  = (ram_cs & ram_read) ? ram_addr[AW-1:0] : rd_addr;
    ready_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          ready_d = 1'b0;
          cs_d    = 1'b1;
          write_d = ~cmd_op[0];
          read_d  = cmd_op[0];
          addr_d  = RAM_AW'(cmd_addr);
          wdata_d = cmd_data;
          cnt_d   = cmd_op[1] ? cmd_len : '0;
          inc_d   = (cmd_op == OP_FILL) && cmd_inc;
          state_d = cmd_op[0] ? RD : WR;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cs_d    = 1'b1;
          write_d = 1'b1;
          addr_d  = RAM_AW'(addr_inc);
          wdata_d = ram_wdata + DW'(inc_q);
          cnt_d   = cnt_q - AW'(1);
        end
      end
      RD: begin
        // The last read word comes back one cycle after its strobe, so the
        // completion pulse is issued from DRAIN alongside that word.
        if (cnt_q == '0) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end else begin
          cs_d    = 1'b1;
          read_d  = 1'b1;
          addr_d  = RAM_AW'(addr_inc);
          cnt_d   = cnt_q - AW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      inc_q     <= 1'b0;
      ram_cs    <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inc_q     <= inc_d;
      ram_cs    <= cs_d;
      ram_read  <= read_d;
      ram_write <= write_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      rd_valid  <= rd_valid_d;
      rd_addr   <= rd_addr_d;
      cmd_ready <= ready_d;
      busy      <= ~ready_d;
      done      <= done_d;
    end
  end

endmodule
